clock_div_prog: RTL
===================

// Module: clock_div_prog
// PURPOSE
//  Multi-channel programmable clock-enable generator; fabric-logic successor to the fixed /2 buffer divider.
//  Each channel divides CLK_I by a runtime-loadable ratio. It emits a one-cycle enable strobe and a registered square wave.
//  Ratio changes apply glitch-free at a period boundary. Used for peripheral tick generation (UART, timers, 7-seg scan)
//  without consuming global clock buffers.
// PARAMETERS
//  NUM_CH   2   number of independent divider channels
//  CNT_W    16  width of divide ratio and per-channel counter
//  DEF_DIV  2   divide ratio loaded into every channel at reset (1..2^CNT_W-1)
// PORTS
//  CLK_I   in   1             single clock; all logic on rising edge
//  RST_I   in   1             synchronous reset, active-high
//  DIV_I   in   NUM_CH*CNT_W  new ratio per channel; channel n uses bits [n*CNT_W +: CNT_W]
//  LOAD_I  in   NUM_CH        per-channel strobe: capture DIV_I slice into pending register
//  EN_I    in   NUM_CH        per-channel run enable
//  CE_O    out  NUM_CH        one-cycle clock-enable strobe, once per period
//  CLK_O   out  NUM_CH        registered divided square wave (used as data/enable, never as a clock)
//  PEND_O  out  NUM_CH        pending ratio captured, not yet applied
// BEHAVIOUR
//  Per-channel state: active ratio D, pending ratio P, pend flag, counter cnt (CNT_W bits). Channels are fully independent.
//  Reset (RST_I=1 at an edge): D=DEF_DIV, P=DEF_DIV, pend=0, cnt=0, CE_O=0, CLK_O=0, PEND_O=0. RST_I overrides all inputs.
//   Reset mid-period abandons the period; no partial strobe is emitted.
//  Ratio rule: loaded value 0 is stored as 1; D=1 gives CE_O high every enabled cycle and CLK_O constantly high.
//  Enabled edge (EN_I=1):
//   - cnt <= (cnt==D-1) ? 0 : cnt+1
//   - CE_O <= (cnt==D-1)
//   - CLK_O <= (cnt >= D>>1), so CLK_O is low floor(D/2) cycles and high ceil(D/2) cycles per period
//   - All outputs are flops; there is no combinational input->output path.
//  Disabled edge (EN_I=0): cnt<=0, CE_O<=0, CLK_O<=0. If pend=1, then D<=P and pend<=0 at the same edge.
//  Boundary: an edge with EN_I=1 and cnt==D-1 is a wrap. At a wrap with pend=1, D<=P and pend<=0.
//   The new ratio governs from cnt=0 onward; there is never a truncated or stretched period.
//  LOAD_I=1 at an edge: P<=DIV_I slice (0->1), pend<=1. A second load before apply overwrites P (last wins).
//  Simultaneous LOAD_I and wrap: the DIV_I value at that edge is applied directly (D<=new value), pend<=0.
//  Simultaneous LOAD_I and EN_I=0: the value is applied directly, pend<=0.
//  PEND_O = pend (registered). Latency: first CE_O is high after the D-th edge with EN_I sampled high, then every D edges.
//  Toggling EN_I low for one cycle restarts the period from cnt=0.
// TESTING
//  1 Reset, DEF_DIV=2, EN_I=1 -> CE_O pulses every 2nd cycle; first pulse after edge 2; CLK_O alternates 0,1.
//  2 LOAD_I with ratio 4 while disabled, PEND_O->0 next cycle, EN_I=1 -> CE_O after edges 4,8,12; CLK_O 0,0,1,1 repeating.
//  3 Running at D=5: load 3 at cnt=1 -> PEND_O=1 until wrap; the current 5-cycle period completes, then 3-cycle periods.
//  4 Load 7 then 9 before wrap; load in wrap cycle; load 0 -> last value applies; wrap-cycle load applies immediately; 0 acts as 1.
//  5 NUM_CH=2, ch0 D=3 and ch1 D=1, toggle EN_I[0] -> ch1 CE_O continuously high; ch0 restarts cleanly.
//  6 Assert RST_I mid-period and with LOAD_I/EN_I high -> all outputs 0 next cycle, D=DEF_DIV, no stray CE_O.

Source files
------------

// File: rtl/clock_div_prog.sv
// Multi-channel programmable clock-enable generator.
// Each channel emits a one-cycle CE strobe and a registered square wave at CLK_I / ratio.
module clock_div_prog #(
    parameter int NUM_CH  = 2,
    parameter int CNT_W   = 16,
    parameter int DEF_DIV = 2
) (
    input  logic                    CLK_I,
    input  logic                    RST_I,
    input  logic [NUM_CH*CNT_W-1:0] DIV_I,
    input  logic [NUM_CH-1:0]       LOAD_I,
    input  logic [NUM_CH-1:0]       EN_I,
    output logic [NUM_CH-1:0]       CE_O,
    output logic [NUM_CH-1:0]       CLK_O,
    output logic [NUM_CH-1:0]       PEND_O
);

    localparam logic [CNT_W-1:0] DEF_D = (DEF_DIV < 1) ? CNT_W'(1) : CNT_W'(DEF_DIV);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_W-1:0] r_div;
        logic [CNT_W-1:0] r_pdiv;
        logic [CNT_W-1:0] r_cnt;
        logic             r_pend;
        logic             r_ce;
        logic             r_clk;
        logic [CNT_W-1:0] w_slice;
        logic [CNT_W-1:0] w_newdiv;
        logic [CNT_W-1:0] w_last;
        logic             w_wrap;
        logic             w_bound;

        // A ratio may only change at a period boundary: a wrap, or any disabled edge.
        always_comb begin
            w_slice  = DIV_I[g*CNT_W +: CNT_W];
            w_newdiv = (w_slice == '0) ? CNT_W'(1) : w_slice;
            w_last   = r_div - CNT_W'(1);
            w_wrap   = EN_I[g] && (r_cnt == w_last);
            w_bound  = w_wrap || !EN_I[g];
        end

        always_ff @(posedge CLK_I) begin
            if (RST_I) begin
                r_div  <= DEF_D;
                r_pdiv <= DEF_D;
                r_cnt  <= '0;
                r_pend <= 1'b0;
                r_ce   <= 1'b0;
                r_clk  <= 1'b0;
            end else begin
                if (EN_I[g]) begin
                    r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);
                    r_ce  <= w_wrap;
                    r_clk <= (r_cnt >= (r_div >> 1));
                end else begin
                    r_cnt <= '0;
                    r_ce  <= 1'b0;
                    r_clk <= 1'b0;
                end

                if (LOAD_I[g]) begin
                    r_pdiv <= w_newdiv;
                    if (w_bound) begin
                        r_div  <= w_newdiv;
                        r_pend <= 1'b0;
                    end else begin
                        r_pend <= 1'b1;
                    end
                end else if (w_bound && r_pend) begin
                    r_div  <= r_pdiv;
                    r_pend <= 1'b0;
                end
            end
        end

        assign CE_O[g]   = r_ce;
        assign CLK_O[g]  = r_clk;
        assign PEND_O[g] = r_pend;
    end

endmodule
